// File: rtl/pcu_pkg.sv
// pcu_pkg: shared constants and types for the paint control unit
package pcu_pkg;
   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, CLEAR} state_t;
   localparam logic [7:0]  RESET_COORD = 8'd128;
   localparam logic [11:0] CLEAR_COLOR = 12'hFFF;
endpackage

// File: rtl/pcu_debounce.sv
// debounce: two-flop synchroniser plus level debouncer for one raw input bit
// Ports: clk, rst (sync, active-high), din (raw async level), dout (debounced level)
module debounce #(
   parameter int CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   localparam int W = $clog2(CYCLES + 1);
   logic         sync1_q, sync2_q, dout_q, dout_d;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d  = '0;
      dout_d = dout_q;
      if (sync2_q != dout_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == W'(CYCLES - 1)) begin
            cnt_d  = '0;
            dout_d = sync2_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end
   assign dout = dout_q;
endmodule

// File: rtl/pcu.sv
// pcu: paint control unit, turns buttons into cursor moves and VRAM writes
// Ports: clk, rst (sync, active-high); dir[3:0] up/down/left/right, draw, rgb[11:0] raw inputs;
//        x, y cursor; we, paddr = {x, y}, pdata = {4'b0, colour} VRAM write port;
//        clr raw clear button, present only when PCU_CLEAR_EN is defined.
module pcu
   import pcu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  dir,
   input  logic        draw,
   input  logic [11:0] rgb,
   output logic [7:0]  x,
   output logic [7:0]  y,
   output logic        we,
   output logic [15:0] paddr,
   output logic [15:0] pdata
`ifdef PCU_CLEAR_EN
   ,
   input  logic        clr
`endif
);
   localparam int CMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(CMAX + 1);
   logic [3:0]    dir_db, dir_prev_q;
   logic          draw_db, step, rise, held, moving;
   logic [7:0]    dx, dy, x_q, x_d, y_q, y_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [15:0]   paddr_q, paddr_d, pdata_q, pdata_d;
   genvar g;
   for (g = 0; g < 4; g++) begin : g_dir
      debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dir (.clk(clk), .rst(rst), .din(dir[g]), .dout(dir_db[g]));
   end
   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_draw (.clk(clk), .rst(rst), .din(draw), .dout(draw_db));
`ifdef PCU_CLEAR_EN
   logic        clr_db, clr_prev_q;
   logic [15:0] caddr_q, caddr_d;
   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst(rst), .din(clr), .dout(clr_db));
`endif
   // Opposing buttons cancel; -1 is expressed as 8'hFF so the add wraps modulo 256.
   assign dx = (dir_db[DIR_RIGHT] & ~dir_db[DIR_LEFT]) ? 8'd1 :
               (dir_db[DIR_LEFT] & ~dir_db[DIR_RIGHT]) ? 8'hFF : 8'd0;
   assign dy = (dir_db[DIR_DOWN] & ~dir_db[DIR_UP]) ? 8'd1 :
               (dir_db[DIR_UP] & ~dir_db[DIR_DOWN]) ? 8'hFF : 8'd0;
   assign moving = (|dx) | (|dy);
   assign rise   = |(dir_db & ~dir_prev_q);
   assign held   = |dir_db;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      step    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise && moving) begin
               step    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD:
            if (!held) state_d = IDLE;
            else if (cnt_q == CW'(REPEAT_DELAY - 1)) begin
               step    = 1'b1;
               state_d = REPEAT;
               cnt_d   = '0;
            end
         REPEAT:
            if (!held) state_d = IDLE;
            else if (cnt_q == CW'(REPEAT_PERIOD - 1)) begin
               step  = 1'b1;
               cnt_d = '0;
            end
         default: ;
      endcase
      we_d    = draw_db;
      paddr_d = draw_db ? {x_q, y_q} : paddr_q;
      pdata_d = draw_db ? {4'b0, rgb} : pdata_q;
`ifdef PCU_CLEAR_EN
      caddr_d = caddr_q + 1'b1;
      if (state_q == CLEAR) begin
         we_d    = 1'b1;
         paddr_d = caddr_q;
         pdata_d = {4'b0, CLEAR_COLOR};
         if (caddr_q == 16'hFFFF) state_d = IDLE;
      end
      // Entry cycle writes nothing so the clear burst is exactly 65536 writes long.
      if (clr_db && !clr_prev_q) begin
         state_d = CLEAR;
         caddr_d = '0;
         step    = 1'b0;
         we_d    = 1'b0;
         paddr_d = paddr_q;
         pdata_d = pdata_q;
      end
`endif
      x_d = step ? x_q + dx : x_q;
      y_d = step ? y_q + dy : y_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dir_prev_q <= '0;
         x_q        <= RESET_COORD;
         y_q        <= RESET_COORD;
         we_q       <= 1'b0;
         paddr_q    <= '0;
         pdata_q    <= '0;
`ifdef PCU_CLEAR_EN
         clr_prev_q <= 1'b0;
         caddr_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_prev_q <= dir_db;
         x_q        <= x_d;
         y_q        <= y_d;
         we_q       <= we_d;
         paddr_q    <= paddr_d;
         pdata_q    <= pdata_d;
`ifdef PCU_CLEAR_EN
         clr_prev_q <= clr_db;
         caddr_q    <= caddr_d;
`endif
      end
   end
   assign x     = x_q;
   assign y     = y_q;
   assign we    = we_q;
   assign paddr = paddr_q;
   assign pdata = pdata_q;
endmodule

// File: tb/tb_pcu.sv
// tb_pcu: directed self-checking bench for pcu with short debounce/repeat timing
module tb_pcu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  dir = 4'b0;
   logic        draw = 1'b0;
   logic [11:0] rgb = 12'h0;
   logic [7:0]  x, y;
   logic        we;
   logic [15:0] paddr, pdata;
   int          checks = 0;
   int          failures = 0;
`ifdef PCU_CLEAR_EN
   logic        clr = 1'b0;
`endif
   pcu #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
      .clk(clk), .rst(rst), .dir(dir), .draw(draw), .rgb(rgb),
      .x(x), .y(y), .we(we), .paddr(paddr), .pdata(pdata)
`ifdef PCU_CLEAR_EN
      , .clr(clr)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      int  prev;
      bit  seen;
      tick(3);
      rst = 1'b0;
      tick(10);
      chk("rst_x", x, 128);
      chk("rst_y", y, 128);
      chk("rst_we", we, 0);
      chk("rst_paddr", paddr, 0);
      // single right press: step lands 2+4+1 edges after the press
      dir = 4'b1000;
      tick(8);
      dir = 4'b0000;
      tick(12);
      chk("pulse_x", x, 129);
      chk("pulse_y", y, 128);
      dir = 4'b0001;
      tick(2);
      dir = 4'b0000;
      tick(12);
      chk("glitch_y", y, 128);
      chk("glitch_x", x, 129);
      // held right: first step at +7, repeat at +27, then every 5
      dir = 4'b1000;
      tick(6);
      chk("rep_e6", x, 129);
      tick(1);
      chk("rep_e7", x, 130);
      tick(19);
      chk("rep_e26", x, 130);
      tick(1);
      chk("rep_e27", x, 131);
      tick(4);
      chk("rep_e31", x, 131);
      tick(1);
      chk("rep_e32", x, 132);
      tick(18);
      chk("rep_e50", x, 135);
      dir = 4'b0000;
      tick(2);
      chk("rep_e52", x, 136);
      tick(20);
      chk("rep_release", x, 136);
      dir = 4'b0011;
      tick(40);
      chk("updown_y", y, 128);
      chk("updown_x", x, 136);
      dir = 4'b0000;
      tick(20);
      // left until x wraps 0 -> 255
      dir = 4'b0100;
      prev = int'(x);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         tick(1);
         if (int'(x) != prev) begin
            if (prev == 0) begin
               chk("x_wrap", x, 255);
               seen = 1'b1;
            end
            prev = int'(x);
         end
      end
      if (!seen) chk("x_wrap_timeout", 0, 1);
      dir = 4'b0000;
      tick(20);
      // up until y wraps 0 -> 255
      dir = 4'b0001;
      prev = int'(y);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         tick(1);
         if (int'(y) != prev) begin
            if (prev == 0) begin
               chk("y_wrap", y, 255);
               seen = 1'b1;
            end
            prev = int'(y);
         end
      end
      if (!seen) chk("y_wrap_timeout", 0, 1);
      dir = 4'b0000;
      tick(20);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      chk("rst2_x", x, 128);
      dir = 4'b1000;
      tick(8);
      dir = 4'b0000;
      tick(12);
      chk("pos_x", x, 129);
      // drawing at (129,128)
      rgb  = 12'hA5C;
      draw = 1'b1;
      tick(6);
      chk("draw_we_e6", we, 0);
      tick(1);
      chk("draw_we_e7", we, 1);
      chk("draw_paddr", paddr, 16'h8180);
      chk("draw_pdata", pdata, 16'h0A5C);
      dir = 4'b1000;
      tick(7);
      chk("trail_x", x, 130);
      chk("trail_paddr_old", paddr, 16'h8180);
      tick(1);
      chk("trail_paddr_new", paddr, 16'h8280);
      dir = 4'b0000;
      tick(12);
      draw = 1'b0;
      tick(6);
      chk("undraw_we_e6", we, 1);
      tick(1);
      chk("undraw_we_e7", we, 0);
      tick(5);
`ifdef PCU_CLEAR_EN
      begin
         int bad;
         int w;
         bad = 0;
         clr = 1'b1;
         tick(8);
         clr = 1'b0;
         w = 0;
         while (!we && w < 50) begin
            tick(1);
            w++;
         end
         chk("clr_start", we, 1);
         for (int i = 0; i < 65536; i++) begin
            if (!(we === 1'b1 && paddr === 16'(i) && pdata === 16'h0FFF && x === 8'd130 && y === 8'd128)) bad++;
            tick(1);
         end
         chk("clr_writes_bad", bad, 0);
         chk("clr_end_we", we, 0);
         chk("clr_x", x, 130);
         chk("clr_y", y, 128);
         clr = 1'b1;
         tick(8);
         clr = 1'b0;
         w = 0;
         while (!we && w < 50) begin
            tick(1);
            w++;
         end
         chk("clr2_start", we, 1);
         tick(100);
         rst = 1'b1;
         tick(1);
         chk("clr_rst_we", we, 0);
         rst = 1'b0;
         tick(2);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
